// File: rtl/alu16b_bist_if.sv
// alu16b_bist_if: operand/result bus between the BIST driver and alu16b.
// master drives op/inv/A/B and samples R/ovfl/zero; slave is the ALU side.
interface alu16b_bist_if;
  logic [2:0]  op;
  logic        inv;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] R;
  logic        ovfl;
  logic        zero;

  modport master (
    output op, inv, A, B,
    input  R, ovfl, zero
  );

  modport slave (
    input  op, inv, A, B,
    output R, ovfl, zero
  );
endinterface

// File: rtl/alu16b_bist_driver.sv
// alu16b_bist_driver: runs NUM_VEC ROM vectors through alu16b, counts mismatches.
// Optional first-mismatch capture of R/flags with `define ALU_BIST_CAPTURE_EN.
module alu16b_bist_driver #(
  parameter int NUM_VEC    = 8,
  parameter int IDX_W      = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] vec_idx,
  input  logic [2:0]       vec_op,
  input  logic             vec_inv,
  input  logic [15:0]      vec_A,
  input  logic [15:0]      vec_B,
  input  logic [15:0]      vec_R,
  input  logic             vec_ovfl,
  input  logic             vec_zero,
  alu16b_bist_if.master    alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   fail_cnt,
  output logic [IDX_W-1:0] first_fail,
  output logic [15:0]      cap_R,
  output logic [1:0]       cap_flags
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VEC - 1);
  localparam logic [IDX_W:0]   FMAX = (IDX_W + 1)'(NUM_VEC);
  localparam logic [3:0]       SMAX = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t st, nxt;

  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic [15:0]      exp_r;
  logic             exp_ovfl;
  logic             exp_zero;

  logic accept, ld, sett, chk, fin, mis, last;

  assign vec_idx = idx;
  assign last    = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE, S_DONE: if (start) nxt = S_LOAD;
      S_LOAD:         nxt = S_SETTLE;
      S_SETTLE:       if (cnt == SMAX) nxt = S_CHECK;
      S_CHECK:        nxt = last ? S_DONE : S_LOAD;
      default:        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    ld     = 1'b0;
    sett   = 1'b0;
    chk    = 1'b0;
    fin    = 1'b0;
    unique case (1'b1)
      (st == S_IDLE):   accept = start;
      (st == S_LOAD):   ld     = 1'b1;
      (st == S_SETTLE): sett   = 1'b1;
      (st == S_CHECK):  chk    = 1'b1;
      (st == S_DONE): begin
        accept = start;
        fin    = ~start;
      end
      default: ;
    endcase
    mis = (alu.R != exp_r) |
          (alu.ovfl != exp_ovfl) |
          (alu.zero != exp_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      exp_r      <= '0;
      exp_ovfl   <= 1'b0;
      exp_zero   <= 1'b0;
      alu.op     <= '0;
      alu.inv    <= 1'b0;
      alu.A      <= '0;
      alu.B      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else begin
      if (accept) begin
        idx        <= '0;
        fail_cnt   <= '0;
        first_fail <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
      end
      if (fin) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (fail_cnt == '0);
      end
      if (ld) begin
        alu.op   <= vec_op;
        alu.inv  <= vec_inv;
        alu.A    <= vec_A;
        alu.B    <= vec_B;
        exp_r    <= vec_R;
        exp_ovfl <= vec_ovfl;
        exp_zero <= vec_zero;
        cnt      <= '0;
      end
      if (sett) cnt <= cnt + 4'd1;
      if (chk) begin
        if (mis) begin
          if (fail_cnt == '0) first_fail <= idx;
          if (fail_cnt != FMAX) fail_cnt <= fail_cnt + 1'b1;
        end
        if (!last) idx <= idx + 1'b1;
      end
    end
  end

`ifdef ALU_BIST_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_R     <= '0;
      cap_flags <= '0;
    end else if (accept) begin
      cap_R     <= '0;
      cap_flags <= '0;
    end else if (chk && mis && (fail_cnt == '0)) begin
      cap_R     <= alu.R;
      cap_flags <= {alu.ovfl, alu.zero};
    end
  end
`else
  assign cap_R     = '0;
  assign cap_flags = '0;
`endif

endmodule
